nvlink_flit_rx_check: RTL and testbench
=======================================

Name: nvlink_flit_rx_check

Overview:
- Receive-side companion to the NVLink-style framing encoder.
- Unpacks flits of format {coherence[COH_W], seq_id[SEQ_W], payload[PAYLOAD_W]} and checks that sequence IDs are contiguous (wrap-around allowed).
- Buffers in-order flits in a small FIFO with valid/ready output to the upper layer; drops out-of-order flits and counts errors.
- Input side has no backpressure, matching the encoder's valid-only output.

Parameters:
- PAYLOAD_W, 96, payload field width.
- COH_W, 8, coherence field width.
- SEQ_W, 24, sequence ID field width.
- FIFO_DEPTH, 4, output buffer entries; power of two, ≥2.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  flit_in valid this cycle; always accepted.
- flit_in  input  PAYLOAD_W+COH_W+SEQ_W  encoded flit; coherence in MSBs, then seq, payload in LSBs.
- resync  input  1  one-cycle pulse that forces the HUNT state.
- valid_out  output  1  FIFO head valid.
- ready_in  input  1  upper layer accepts the head.
- payload_out  output  PAYLOAD_W  head payload.
- coh_out  output  COH_W  head coherence bits.
- seq_out  output  SEQ_W  head sequence ID.
- locked  output  1  checker is in LOCK.
- seq_err  output  1  one-cycle pulse: flit dropped on sequence mismatch.
- ovf_err  output  1  one-cycle pulse: in-order flit dropped because the FIFO was full.
- seq_err_cnt  output  CNT_W  saturating count of seq_err pulses.
- ovf_err_cnt  output  CNT_W  saturating count of ovf_err pulses.

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs 0; state = HUNT; FIFO empty; expected_seq = 0.
- Field extraction:
  - rx_coh = flit_in[top COH_W bits].
  - rx_seq = flit_in[PAYLOAD_W+SEQ_W-1:PAYLOAD_W].
  - rx_pay = flit_in[PAYLOAD_W-1:0].
- FSM states:
  - HUNT:
    - valid_in is treated as in-order regardless of rx_seq.
    - expected_seq <= rx_seq+1 (mod 2^SEQ_W).
    - Flit offered to the FIFO.
    - Next state LOCK.
  - LOCK, valid_in with rx_seq == expected_seq:
    - expected_seq <= expected_seq+1 (wraps 2^SEQ_W-1 → 0).
    - Flit offered to the FIFO.
  - LOCK, valid_in with mismatch:
    - Flit dropped; seq_err pulses the next cycle.
    - Next state HUNT; expected_seq unchanged.
  - resync=1: next state HUNT; the same-cycle flit is still processed under the current-state rules.
- locked = (state == LOCK), registered.
- FIFO push/pop:
  - Push when the flit is offered and (not full, or a pop occurs the same cycle).
  - Pop when valid_out && ready_in.
  - Full plus simultaneous pop: push succeeds, no overflow.
  - Offered flit with FIFO full and no pop:
    - Flit dropped; ovf_err pulses next cycle.
    - expected_seq still advances (the flit was in-order).
- Latency:
  - Flit presented at edge N appears on valid_out after edge N+1 (registered, no fall-through).
  - Back-to-back flits are accepted every cycle.
- Output holding:
  - valid_out and the head fields are stable while valid_out && !ready_in.
  - The head data is don't-care when valid_out=0, but the bench expects 0 after reset.
- Counters:
  - Each counter increments by 1 per pulse and saturates at 2^CNT_W-1.
  - seq_err and ovf_err cannot both assert for the same flit.
- Reset mid-operation: FIFO contents are discarded, counters cleared, state HUNT; no partial output.

Test Plan:
- Reset, then seq 0x000010..0x000013 on consecutive cycles with ready_in=1 → valid_out one cycle later each; seq_out 0x10..0x13 in order; locked=1 after the first flit; no errors.
- Seq 0xFFFFFE, 0xFFFFFF, 0x000000 → all three delivered; no seq_err (wrap).
- Locked at expected 5; send 5, 7, 8, 9 → 5 delivered; 7 dropped; seq_err pulse and seq_err_cnt=1; HUNT adopts 8; 8 and 9 delivered.
- ready_in=0; send 6 in-order flits into FIFO_DEPTH=4 → 4 buffered; 2 ovf_err pulses; ovf_err_cnt=2; then ready_in=1 drains exactly the first 4 in order; the next flit (seq+6) is accepted without seq_err.
- FIFO full and ready_in=1, with valid_in the same cycle → push and pop both occur; no ovf_err; occupancy stays 4.
- resync pulse while LOCK, followed by flit seq 0x123 → accepted; locked re-asserts; expected becomes 0x124; assert rst_n low with 3 flits buffered → valid_out=0 immediately, counters=0.

Source files
------------

// File: rtl/nvlink_flit_rx_check.sv
// Flit RX checker: unpacks flits, enforces contiguous seq IDs, buffers in-order flits; 1-cycle latency in->out.
// Input is never backpressured (drops counted as seq/ovf errors); output is valid/ready, head held while stalled.
module nvlink_flit_rx_check #(
  parameter int PAYLOAD_W  = 96,
  parameter int COH_W      = 8,
  parameter int SEQ_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               valid_in,
  input  logic [PAYLOAD_W+COH_W+SEQ_W-1:0]   flit_in,
  input  logic                               resync,
  output logic                               valid_out,
  input  logic                               ready_in,
  output logic [PAYLOAD_W-1:0]               payload_out,
  output logic [COH_W-1:0]                   coh_out,
  output logic [SEQ_W-1:0]                   seq_out,
  output logic                               locked,
  output logic                               seq_err,
  output logic                               ovf_err,
  output logic [CNT_W-1:0]                   seq_err_cnt,
  output logic [CNT_W-1:0]                   ovf_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [COH_W-1:0]     coh;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] pay;
  } flit_t;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
  logic             seq_err_q, seq_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] seq_cnt_q, ovf_cnt_q;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  flit_t            mem_q [FIFO_DEPTH];

  flit_t rx;
  flit_t head;
  logic  offer;
  logic  push;
  logic  pop;
  logic  fifo_empty;
  logic  fifo_full;

  assign rx = flit_in;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign valid_out = !fifo_empty;
  assign pop       = valid_out && ready_in;

  always_comb begin
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    offer     = 1'b0;
    seq_err_d = 1'b0;
    if (valid_in) begin
      if (state_q == HUNT) begin
        offer     = 1'b1;
        exp_seq_d = rx.seq + SEQ_W'(1);
        state_d   = LOCK;
      end else if (rx.seq == exp_seq_q) begin
        offer     = 1'b1;
        exp_seq_d = exp_seq_q + SEQ_W'(1);
      end else begin
        seq_err_d = 1'b1;
        state_d   = HUNT;
      end
    end
    if (resync) begin
      state_d = HUNT;
    end
    // A simultaneous pop frees a slot, so a full FIFO still takes the flit.
    push      = offer && (!fifo_full || pop);
    ovf_err_d = offer && !push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      exp_seq_q <= '0;
      seq_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      seq_cnt_q <= '0;
      ovf_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      exp_seq_q <= exp_seq_d;
      seq_err_q <= seq_err_d;
      ovf_err_q <= ovf_err_d;
      if (seq_err_d && (seq_cnt_q != {CNT_W{1'b1}})) begin
        seq_cnt_q <= seq_cnt_q + CNT_W'(1);
      end
      if (ovf_err_d && (ovf_cnt_q != {CNT_W{1'b1}})) begin
        ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx;
    end
  end

  // Storage is not reset, so head fields are forced to zero while empty.
  assign payload_out = valid_out ? head.pay : '0;
  assign coh_out     = valid_out ? head.coh : '0;
  assign seq_out     = valid_out ? head.seq : '0;

  assign locked      = (state_q == LOCK);
  assign seq_err     = seq_err_q;
  assign ovf_err     = ovf_err_q;
  assign seq_err_cnt = seq_cnt_q;
  assign ovf_err_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_nvlink_flit_rx_check.sv
// Directed bench for nvlink_flit_rx_check: lock/wrap, seq drop, overflow, full push+pop, resync, async reset.
module tb_nvlink_flit_rx_check;
  localparam int PW = 96;
  localparam int CW = 8;
  localparam int SW = 24;
  localparam int NW = 16;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [127:0]  flit_in;
  logic          resync;
  logic          valid_out;
  logic          ready_in;
  logic [PW-1:0] payload_out;
  logic [CW-1:0] coh_out;
  logic [SW-1:0] seq_out;
  logic          locked;
  logic          seq_err;
  logic          ovf_err;
  logic [NW-1:0] seq_err_cnt;
  logic [NW-1:0] ovf_err_cnt;

  int checks = 0;
  int errors = 0;

  nvlink_flit_rx_check #(
    .PAYLOAD_W(PW), .COH_W(CW), .SEQ_W(SW), .FIFO_DEPTH(4), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flit_in(flit_in),
    .resync(resync), .valid_out(valid_out), .ready_in(ready_in),
    .payload_out(payload_out), .coh_out(coh_out), .seq_out(seq_out),
    .locked(locked), .seq_err(seq_err), .ovf_err(ovf_err),
    .seq_err_cnt(seq_err_cnt), .ovf_err_cnt(ovf_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [23:0] s);
    return {s[7:0] ^ 8'h5A, s, s, s, s, s};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] s);
    valid_in = 1'b1;
    flit_in  = mk(s);
    cyc();
    valid_in = 1'b0;
    flit_in  = '0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [23:0] s);
    logic [127:0] f;
    f = mk(s);
    checks++;
    assert (valid_out === 1'b1 && seq_out === s && payload_out === f[95:0] && coh_out === f[127:120]) else begin
      errors++;
      $error("FAIL %s: observed vld=%0b seq=%0h coh=%0h pay=%0h expected vld=1 seq=%0h coh=%0h pay=%0h",
             tag, valid_out, seq_out, coh_out, payload_out, s, f[127:120], f[95:0]);
    end
  endtask

  task automatic chk_zero_head(input string tag);
    checks++;
    assert (valid_out === 1'b0 && seq_out === '0 && payload_out === '0 && coh_out === '0) else begin
      errors++;
      $error("FAIL %s: observed vld=%0b seq=%0h coh=%0h pay=%0h expected all zero",
             tag, valid_out, seq_out, coh_out, payload_out);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    flit_in  = '0;
    resync   = 1'b0;
    ready_in = 1'b0;
    cyc();
    cyc();
    chk_zero_head("rst_head");
    chk1("rst_locked", locked, 1'b0);
    chk1("rst_seq_err", seq_err, 1'b0);
    chk1("rst_ovf_err", ovf_err, 1'b0);
    chk_cnt("rst_seq_cnt", seq_err_cnt, 16'd0);
    chk_cnt("rst_ovf_cnt", ovf_err_cnt, 16'd0);
    rst_n = 1'b1;
    cyc();

    // Lock on 0x10 and stream 0x10..0x13 back to back.
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(24'h10 + 24'(i));
      chk_head("stream_head", 24'h10 + 24'(i));
      chk1("stream_locked", locked, 1'b1);
      chk1("stream_seq_err", seq_err, 1'b0);
    end
    cyc();
    chk1("stream_drained", valid_out, 1'b0);

    // Rehunt, then cross the sequence wrap.
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk1("resync_unlock", locked, 1'b0);
    send(24'hFFFFFE);
    chk_head("wrap_fe", 24'hFFFFFE);
    send(24'hFFFFFF);
    chk_head("wrap_ff", 24'hFFFFFF);
    chk1("wrap_ff_err", seq_err, 1'b0);
    send(24'h000000);
    chk_head("wrap_00", 24'h000000);
    chk1("wrap_00_err", seq_err, 1'b0);
    cyc();
    chk_cnt("wrap_seq_cnt", seq_err_cnt, 16'd0);

    // Lock with expected 5, then 5, 7 (dropped), 8, 9.
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    send(24'h4);
    send(24'h5);
    chk_head("gap_5", 24'h5);
    send(24'h7);
    chk1("gap_7_dropped", valid_out, 1'b0);
    chk1("gap_7_seq_err", seq_err, 1'b1);
    chk1("gap_7_unlock", locked, 1'b0);
    chk_cnt("gap_7_cnt", seq_err_cnt, 16'd1);
    send(24'h8);
    chk_head("gap_8", 24'h8);
    chk1("gap_8_pulse_end", seq_err, 1'b0);
    chk1("gap_8_locked", locked, 1'b1);
    send(24'h9);
    chk_head("gap_9", 24'h9);
    cyc();

    // Stall output and push six in-order flits into four entries.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(24'hA + 24'(i));
    end
    chk_head("ovf_head_hold", 24'hA);
    chk1("ovf_none_yet", ovf_err, 1'b0);
    send(24'hE);
    chk1("ovf_e_pulse", ovf_err, 1'b1);
    chk_cnt("ovf_e_cnt", ovf_err_cnt, 16'd1);
    send(24'hF);
    chk1("ovf_f_pulse", ovf_err, 1'b1);
    chk_cnt("ovf_f_cnt", ovf_err_cnt, 16'd2);
    cyc();
    chk1("ovf_pulse_end", ovf_err, 1'b0);
    chk_head("ovf_head_stable", 24'hA);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("ovf_drain", 24'hA + 24'(i));
      cyc();
    end
    chk1("ovf_drained", valid_out, 1'b0);
    send(24'h10);
    chk_head("ovf_resume", 24'h10);
    chk1("ovf_resume_err", seq_err, 1'b0);
    chk_cnt("ovf_resume_cnt", seq_err_cnt, 16'd1);
    cyc();
    chk1("resume_drained", valid_out, 1'b0);

    // Fill, then push and pop together while full.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(24'h11 + 24'(i));
    end
    ready_in = 1'b1;
    send(24'h15);
    chk1("full_pp_no_ovf", ovf_err, 1'b0);
    chk_head("full_pp_head", 24'h12);
    for (int i = 0; i < 4; i++) begin
      chk_head("full_pp_drain", 24'h12 + 24'(i));
      cyc();
    end
    chk1("full_pp_occupancy", valid_out, 1'b0);
    chk_cnt("full_pp_ovf_cnt", ovf_err_cnt, 16'd2);

    // Resync while locked, relock on 0x123, buffer three, then async reset.
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk1("rs_unlock", locked, 1'b0);
    send(24'h123);
    chk_head("rs_123", 24'h123);
    chk1("rs_relock", locked, 1'b1);
    ready_in = 1'b0;
    send(24'h124);
    chk1("rs_124_no_err", seq_err, 1'b0);
    send(24'h125);
    chk_head("rs_hold", 24'h123);
    chk_cnt("rs_seq_cnt", seq_err_cnt, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_head("arst_head");
    chk1("arst_locked", locked, 1'b0);
    chk_cnt("arst_seq_cnt", seq_err_cnt, 16'd0);
    chk_cnt("arst_ovf_cnt", ovf_err_cnt, 16'd0);
    cyc();
    rst_n = 1'b1;
    ready_in = 1'b1;
    cyc();
    chk_zero_head("post_rst_head");
    chk1("post_rst_locked", locked, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
